// File: rtl/uart_xcvr_fifo_if.sv
// Handshake and serial signals of uart_xcvr_fifo.
// slave = transceiver side, master = user/consumer side.
interface uart_xcvr_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int TX_DEPTH  = 4
);
    localparam int LVL_W = $clog2(TX_DEPTH + 1);

    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic [LVL_W-1:0]     tx_level;
    logic                 tx_busy;
    logic                 ser_tx;
    logic                 ser_rx;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic                 rx_parity_err;

    modport slave (
        input  tx_valid, tx_data, ser_rx, rx_ready,
        output tx_ready, tx_level, tx_busy, ser_tx,
        output rx_valid, rx_data, rx_frame_err, rx_overrun, rx_parity_err
    );

    modport master (
        output tx_valid, tx_data, ser_rx, rx_ready,
        input  tx_ready, tx_level, tx_busy, ser_tx,
        input  rx_valid, rx_data, rx_frame_err, rx_overrun, rx_parity_err
    );
endinterface

// File: rtl/uart_xcvr_fifo.sv
// UART transceiver: TX FIFO plus serializer, RX deserializer with a single holding register.
// Define UART_PARITY_EN to add an even-parity bit in both directions.
module uart_xcvr_fifo #(
    parameter int CLKS_PER_BIT = 4167,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int TX_DEPTH     = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    uart_xcvr_fifo_if.slave bus
);
    localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int LVL_W = $clog2(TX_DEPTH + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(TX_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ZERO  = {LVL_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ZERO  = {BIT_W{1'b0}};

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
`ifdef UART_PARITY_EN
        RX_PARITY    = 3'd3,
`endif
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_e;

    function automatic logic even_par(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    // TX FIFO storage and flags
    logic [DATA_BITS-1:0] fifo_q [TX_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_push_s, tx_pop_s;

    // TX serializer
    tx_state_e            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 ser_tx_q, ser_tx_d;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    // RX deserializer
    logic                 sync1_q, sync2_q, prev_q, fall_s;
    rx_state_e            rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
`ifdef UART_PARITY_EN
    logic                 parity_err_q, parity_err_d;
`endif

    // FIFO pointers, occupancy and registered ready/busy
    always_comb begin
        tx_push_s = bus.tx_valid && tx_ready_q;
        if (tx_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (tx_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({tx_push_s, tx_pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        tx_ready_d = (level_d != LVL_FULL);
        tx_busy_d  = (level_d != LVL_ZERO) || (tx_state_d != TX_IDLE);
    end

    // FIFO register update
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < TX_DEPTH; i++) begin
                fifo_q[i] <= {DATA_BITS{1'b0}};
            end
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            level_q    <= LVL_ZERO;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            if (tx_push_s) begin
                fifo_q[wr_ptr_q] <= bus.tx_data;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    // TX next state: a pop always starts a frame, so STOP can chain straight into START
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        ser_tx_d   = ser_tx_q;
        tx_pop_s   = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            TX_IDLE: begin
                ser_tx_d = 1'b1;
                if (level_q != LVL_ZERO) begin
                    tx_pop_s   = 1'b1;
                    tx_state_d = TX_START;
                    tx_cnt_d   = CNT_ZERO;
                    ser_tx_d   = 1'b0;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = CNT_ZERO;
                    tx_bit_d   = BIT_ZERO;
                    ser_tx_d   = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = CNT_ZERO;
                    if (tx_bit_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PARITY;
                        ser_tx_d   = tx_par_q;
`else
                        tx_state_d = TX_STOP;
                        ser_tx_d   = 1'b1;
`endif
                    end else begin
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                        ser_tx_d   = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_STOP;
                    tx_cnt_d   = CNT_ZERO;
                    ser_tx_d   = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
`endif
            TX_STOP: begin
                if (tx_cnt_q == STOP_LAST) begin
                    tx_cnt_d = CNT_ZERO;
                    if (level_q != LVL_ZERO) begin
                        tx_pop_s   = 1'b1;
                        tx_state_d = TX_START;
                        ser_tx_d   = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                        ser_tx_d   = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                ser_tx_d   = 1'b1;
            end
        endcase
        if (tx_pop_s) begin
            tx_shift_d = fifo_q[rd_ptr_q];
`ifdef UART_PARITY_EN
            tx_par_d   = even_par(fifo_q[rd_ptr_q]);
`endif
        end else begin
            tx_shift_d = tx_shift_d;
        end
    end

    // TX state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= CNT_ZERO;
            tx_bit_q   <= BIT_ZERO;
            tx_shift_q <= {DATA_BITS{1'b0}};
            ser_tx_q   <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            ser_tx_q   <= ser_tx_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign fall_s = prev_q && !sync2_q;

    // RX next state: samples sync2_q at mid-bit; a load always beats a same-cycle consumer clear
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_valid_d  = rx_valid_q && !bus.rx_ready;
        rx_data_d   = rx_data_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_PARITY_EN
        parity_err_d = 1'b0;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                if (fall_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = CNT_ZERO;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = CNT_ZERO;
                    rx_bit_d = BIT_ZERO;
                    if (sync2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_W'(1);
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = CNT_ZERO;
                    if (sync2_q != even_par(rx_shift_q)) begin
                        parity_err_d = 1'b1;
                        rx_state_d   = RX_WAIT_HIGH;
                    end else begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = CNT_ZERO;
                    if (!sync2_q) begin
                        frame_err_d = 1'b1;
                        rx_state_d  = RX_WAIT_HIGH;
                    end else begin
                        rx_state_d = RX_IDLE;
                        if (!rx_valid_q || bus.rx_ready) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = rx_shift_q;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (sync2_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT_HIGH;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // RX synchronizer, state register and holding register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= CNT_ZERO;
            rx_bit_q    <= BIT_ZERO;
            rx_shift_q  <= {DATA_BITS{1'b0}};
            rx_valid_q  <= 1'b0;
            rx_data_q   <= {DATA_BITS{1'b0}};
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= bus.ser_rx;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.tx_ready     = tx_ready_q;
    assign bus.tx_level     = level_q;
    assign bus.tx_busy      = tx_busy_q;
    assign bus.ser_tx       = ser_tx_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.rx_data      = rx_data_q;
    assign bus.rx_frame_err = frame_err_q;
    assign bus.rx_overrun   = overrun_q;
`ifdef UART_PARITY_EN
    assign bus.rx_parity_err = parity_err_q;
`else
    assign bus.rx_parity_err = 1'b0;
`endif

endmodule
